// File: rtl/adc_emu_pkg.sv
// adc_emu_pkg: word geometry, mode encodings, link states and frame helper for the ADC link emulator
package adc_emu_pkg;

    localparam int ADC_BITS      = 12;
    localparam int FRAME_HI_BITS = 6;

    typedef enum logic [1:0] {
        MODE_ZERO  = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_FIXED = 2'd2,
        MODE_EXT   = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // Frame level for the bit about to be shown, with the frame pushed late by slip bit periods
    function automatic logic frame_level(input logic [3:0] idx, input logic [3:0] slip);
        logic [4:0] pos;
        pos = {1'b0, idx} + 5'(ADC_BITS) - {1'b0, slip};
        if (pos >= 5'(ADC_BITS))
            pos = pos - 5'(ADC_BITS);
        return pos < 5'(FRAME_HI_BITS);
    endfunction

endpackage

// File: rtl/adc_emu_serializer.sv
// adc_emu_serializer: one lane's word latch and MSB-first shift register on shared load/shift strobes
module adc_emu_serializer
    import adc_emu_pkg::*;
(
    input  logic                sysclk,
    input  logic                rst,
    input  logic                load,
    input  logic                shift,
    input  logic                clr,
    input  logic [ADC_BITS-1:0] word,
    output logic [ADC_BITS-1:0] held,
    output logic                sdo
);

    logic [ADC_BITS-1:0] sr;

    // held keeps the last loaded word so an external underrun can resend it
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sr   <= '0;
            held <= '0;
        end else if (load) begin
            sr   <= word;
            held <= word;
        end else if (clr) begin
            sr <= '0;
        end else if (shift) begin
            sr <= {sr[ADC_BITS-2:0], 1'b0};
        end
    end

    assign sdo = sr[ADC_BITS-1];

endmodule

// File: rtl/adc_lvds_emulator.sv
// adc_lvds_emulator: serializes 12-bit words onto NUM_CH DDR lanes with bit clock and frame, all on sysclk
// Optional ADC_EMU_BITSLIP_EN adds slip[3:0], delaying adcframe by slip bit periods relative to data.
module adc_lvds_emulator
    import adc_emu_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int CLK_DIV = 2
) (
    input  logic                         sysclk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic [ADC_BITS-1:0]          fixed_word,
    input  logic [NUM_CH*ADC_BITS-1:0]   ext_sample,
    input  logic                         ext_valid,
    output logic                         ext_ready,
    output logic                         adcfastclk,
    output logic                         adcframe,
    output logic [NUM_CH-1:0]            adcdata,
    output logic                         word_strobe,
    output logic [15:0]                  words_sent,
    output logic                         underrun
`ifdef ADC_EMU_BITSLIP_EN
    ,
    input  logic [3:0]                   slip
`endif
);

    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0]       ph;
    logic [3:0]          bit_idx, nxt_idx, slip_eff;
    logic [ADC_BITS-1:0] ramp;
    state_t              state;
    mode_t               m;
    logic                last_ph, upd, load_pt, load, shift, clr, run_nxt;

    assign m       = mode_t'(mode);
    assign last_ph = ph == PW'(CLK_DIV - 1);
    assign upd     = ph == PW'(CLK_DIV / 2 - 1);
    assign load_pt = upd && bit_idx == 4'(ADC_BITS - 1);
    assign load    = load_pt && enable;
    assign shift   = upd && !load_pt;
    assign clr     = load_pt && !enable;
    assign nxt_idx = load_pt ? 4'd0 : bit_idx + 4'd1;
    assign run_nxt = load_pt ? enable : state == ST_RUN;

    assign ext_ready = !rst && load && m == MODE_EXT;

`ifdef ADC_EMU_BITSLIP_EN
    logic [3:0] slip_q, slip_in;
    assign slip_in  = slip > 4'd11 ? 4'd0 : slip;
    assign slip_eff = load ? slip_in : slip_q;

    // Slip is frozen per word so the frame offset never changes mid-word
    always_ff @(posedge sysclk) begin
        if (rst)
            slip_q <= '0;
        else if (load)
            slip_q <= slip_in;
    end
`else
    assign slip_eff = 4'd0;
`endif

    // Phase/bit timing, link state and word bookkeeping; a word only starts or stops at a load point
    always_ff @(posedge sysclk) begin
        if (rst) begin
            ph          <= '0;
            bit_idx     <= 4'(ADC_BITS - 1);
            state       <= ST_IDLE;
            ramp        <= '0;
            adcfastclk  <= 1'b0;
            adcframe    <= 1'b0;
            word_strobe <= 1'b0;
            words_sent  <= '0;
            underrun    <= 1'b0;
        end else begin
            ph          <= last_ph ? '0 : ph + 1'b1;
            word_strobe <= load;
            if (last_ph)
                adcfastclk <= ~adcfastclk;
            if (upd) begin
                bit_idx  <= nxt_idx;
                adcframe <= run_nxt && frame_level(nxt_idx, slip_eff);
            end
            if (load_pt)
                state <= enable ? ST_RUN : ST_IDLE;
            if (load) begin
                words_sent <= words_sent + 1'b1;
                if (m == MODE_RAMP)
                    ramp <= ramp + 1'b1;
                if (m == MODE_EXT && !ext_valid)
                    underrun <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic [ADC_BITS-1:0] held, word;

        // Pattern generator: the word this lane would start at a load point
        always_comb begin
            word = m == MODE_RAMP  ? ramp + ADC_BITS'(c) :
                   m == MODE_FIXED ? fixed_word :
                   m == MODE_EXT   ? (ext_valid ? ext_sample[ADC_BITS*c +: ADC_BITS] : held) :
                                     '0;
        end

        adc_emu_serializer u_ser (
            .sysclk (sysclk),
            .rst    (rst),
            .load   (load),
            .shift  (shift),
            .clr    (clr),
            .word   (word),
            .held   (held),
            .sdo    (adcdata[c])
        );
    end

endmodule

// File: tb/tb_adc_lvds_emulator.sv
// tb_adc_lvds_emulator: cycle-indexed behavioural model of the link plus directed literal checks
module tb_adc_lvds_emulator;

    localparam int NC = 16;
    localparam int CD = 2;

    logic            sysclk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b1;
    logic [1:0]      mode = 2'd1;
    logic [11:0]     fixed_word = '0;
    logic [NC*12-1:0] ext_sample = '0;
    logic            ext_valid = 1'b1;
    logic            ext_ready, adcfastclk, adcframe, word_strobe, underrun;
    logic [NC-1:0]   adcdata;
    logic [15:0]     words_sent;
`ifdef ADC_EMU_BITSLIP_EN
    logic [3:0]      slip = 4'd0;
`endif

    int tests = 0;
    int fails = 0;

    adc_lvds_emulator #(.NUM_CH(NC), .CLK_DIV(CD)) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .fixed_word  (fixed_word),
        .ext_sample  (ext_sample),
        .ext_valid   (ext_valid),
        .ext_ready   (ext_ready),
        .adcfastclk  (adcfastclk),
        .adcframe    (adcframe),
        .adcdata     (adcdata),
        .word_strobe (word_strobe),
        .words_sent  (words_sent),
        .underrun    (underrun)
`ifdef ADC_EMU_BITSLIP_EN
        ,
        .slip        (slip)
`endif
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: k counts cycles since reset; bit updates land every CD cycles, every 12th is a load point
    int              k, load_k, b;
    bit              mvalid = 0, run, strb, lp, und;
    logic [11:0]     cur [NC];
    logic [11:0]     mramp;
    logic [15:0]     mwords;
    logic [NC-1:0]   ed;

    initial begin
        forever begin
            @(negedge sysclk);
            lp = !rst && (k % CD == CD / 2 - 1) && ((k / CD) % 12 == 0);
            if (mvalid) begin
                b = run ? (k - load_k) / CD : 0;
                for (int c = 0; c < NC; c++)
                    ed[c] = run ? cur[c][11 - b] : 1'b0;
                chk("fastclk", 32'(adcfastclk), 32'((k / CD) % 2));
                chk("frame", 32'(adcframe), 32'(run && b < 6));
                chk("data", 32'(adcdata), 32'(ed));
                chk("strobe", 32'(word_strobe), 32'(strb));
                chk("words_sent", 32'(words_sent), 32'(mwords));
                chk("underrun", 32'(underrun), 32'(und));
                chk("ext_ready", 32'(ext_ready), 32'(lp && enable && mode == 2'd3));
            end
            if (rst) begin
                mvalid = 1; k = 0; load_k = 0; run = 0; strb = 0; und = 0;
                mramp = '0; mwords = '0;
                for (int c = 0; c < NC; c++) cur[c] = '0;
            end else if (mvalid) begin
                strb = 0;
                if (lp) begin
                    if (enable) begin
                        for (int c = 0; c < NC; c++)
                            cur[c] = mode == 2'd1 ? mramp + 12'(c) :
                                     mode == 2'd2 ? fixed_word :
                                     mode == 2'd3 ? (ext_valid ? ext_sample[12*c +: 12] : cur[c]) : 12'd0;
                        if (mode == 2'd1) mramp = mramp + 12'd1;
                        if (mode == 2'd3 && !ext_valid) und = 1;
                        mwords = mwords + 16'd1;
                        strb = 1; run = 1; load_k = k + 1;
                    end else begin
                        run = 0;
                    end
                end
                k++;
            end
        end
    end

    logic [11:0]     cap [NC];
    logic [11:0]     capf;
    logic [NC*12-1:0] e1, e2;
    int              scnt;

    task automatic step();
        @(posedge sysclk);
        #2;
    endtask

    task automatic rnd_ext(output logic [NC*12-1:0] v);
        for (int i = 0; i < NC * 12 / 32; i++) v[32*i +: 32] = $urandom;
    endtask

    task automatic wait_strobe(input int lim);
        int n;
        n = 0;
        do begin
            @(negedge sysclk);
            n++;
        end while (word_strobe !== 1'b1 && n < lim);
        chk("strobe_seen", 32'(word_strobe), 32'd1);
    endtask

    // Samples one whole word on every lane, MSB first, starting at the next word strobe
    task automatic capture();
        wait_strobe(200);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) repeat (CD) @(negedge sysclk);
            for (int c = 0; c < NC; c++) cap[c][11 - i] = adcdata[c];
            capf[11 - i] = adcframe;
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_fastclk"}, 32'(adcfastclk), 0);
        chk({nm, "_frame"}, 32'(adcframe), 0);
        chk({nm, "_data"}, 32'(adcdata), 0);
        chk({nm, "_strobe"}, 32'(word_strobe), 0);
        chk({nm, "_words"}, 32'(words_sent), 0);
        chk({nm, "_underrun"}, 32'(underrun), 0);
        chk({nm, "_ready"}, 32'(ext_ready), 0);
    endtask

    initial begin
        // Reset, then ramp from 0: lane c carries c, c+1, ...
        repeat (3) step();
        rst = 1'b0;
        @(negedge sysclk);
        chk_zero("reset");
        capture();
        chk("ramp0_l0", cap[0], 12'd0);
        chk("ramp0_l3", cap[3], 12'd3);
        chk("ramp0_frame", capf, 12'hFC0);
        capture();
        chk("ramp1_l0", cap[0], 12'd1);
        chk("ramp1_l3", cap[3], 12'd4);
        chk("ramp_words", words_sent, 16'd2);

        // Fixed word on every lane
        step();
        mode = 2'd2;
        fixed_word = 12'hA5C;
        wait_strobe(200);
        capture();
        chk("fixed_l0", cap[0], 12'hA5C);
        chk("fixed_l15", cap[15], 12'hA5C);
        chk("fixed_frame", capf, 12'hFC0);

        // External words, then an underrun repeating the previous word
        step();
        mode = 2'd3;
        ext_valid = 1'b1;
        rnd_ext(e1);
        ext_sample = e1;
        wait_strobe(200);
        capture();
        chk("ext_l0", cap[0], e1[11:0]);
        chk("ext_l5", cap[5], e1[12*5 +: 12]);
        chk("ext_no_underrun", underrun, 0);
        step();
        ext_valid = 1'b0;
        rnd_ext(e2);
        ext_sample = e2;
        capture();
        chk("urun_l0", cap[0], e1[11:0]);
        chk("urun_l9", cap[9], e1[12*9 +: 12]);
        chk("urun_flag", underrun, 1);
        step();
        ext_valid = 1'b1;
        wait_strobe(200);
        capture();
        chk("ext2_l9", cap[9], e2[12*9 +: 12]);
        chk("urun_sticky", underrun, 1);

        // Drop enable at bit 3: word completes, then silence
        step();
        mode = 2'd1;
        wait_strobe(200);
        wait_strobe(200);
        repeat (3 * CD) @(negedge sysclk);
        step();
        enable = 1'b0;
        scnt = 0;
        repeat (14 * CD) begin
            @(negedge sysclk);
            if (word_strobe) scnt++;
        end
        chk("drop_strobes", scnt, 0);
        chk("drop_frame", adcframe, 0);
        chk("drop_data", adcdata, 0);
        step();
        enable = 1'b1;
        wait_strobe(12 * CD + 2);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step();
            enable = $urandom_range(0, 7) != 0;
            mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) fixed_word = 12'($urandom);
            ext_valid = $urandom_range(0, 3) != 0;
            rnd_ext(e2);
            ext_sample = e2;
            rst = $urandom_range(0, 499) == 0;
        end
        step();
        rst = 1'b0;
        enable = 1'b1;
        mode = 2'd1;

        // Reset mid-word: outputs clear at once, ramp restarts at 0
        wait_strobe(200);
        repeat (5) @(negedge sysclk);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge sysclk);
        chk_zero("midrst");
        capture();
        chk("rst_ramp_l0", cap[0], 12'd0);
        chk("rst_ramp_l3", cap[3], 12'd3);

        repeat (4) @(negedge sysclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1, "watchdog");
    end

endmodule
